// File: rtl/led_fade_pkg.sv
// Shared types and default constants for the LED fade driver.
package led_fade_pkg;

    typedef enum logic [1:0] {
        IDLE_OFF  = 2'd0,
        RAMP_UP   = 2'd1,
        HOLD_ON   = 2'd2,
        RAMP_DOWN = 2'd3
    } fade_state_e;

    localparam int PWM_BITS_DEF    = 8;
    localparam int STEP_CYCLES_DEF = 98039;

endpackage

// File: rtl/led_fade_driver_pwm_compare.sv
// Free-running PWM counter with registered duty comparators for both LEDs.
module pwm_compare
    import led_fade_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [PWM_BITS:0]   duty,
    input  logic                enable,
    output logic [1:0]          led
);

    localparam logic [PWM_BITS:0] DMAX = {1'b1, {PWM_BITS{1'b0}}};

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS:0]   cnt_ext;
    logic [PWM_BITS:0]   duty_inv;

    // Comparisons are done at PWM_BITS+1 so duty=DMAX yields a constant-high output.
    assign cnt_ext  = {1'b0, pwm_cnt};
    assign duty_inv = DMAX - duty;

    // Counter wraps naturally at 2^PWM_BITS and keeps running while disabled.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) pwm_cnt <= '0;
        else          pwm_cnt <= pwm_cnt + 1'b1;
    end

    // Registered compare; both LEDs go dark on the first edge after disable,
    // before the forced duty=0 has propagated.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            led <= 2'b00;
        end else begin
            led[0] <= enable && (cnt_ext < duty);
            led[1] <= enable && (cnt_ext < duty_inv);
        end
    end

endmodule

// File: rtl/led_fade_driver.sv
// Turns blink level changes into PWM fade-in / fade-out ramps on two LEDs.
module led_fade_driver
    import led_fade_pkg::*;
#(
    parameter int PWM_BITS    = PWM_BITS_DEF,
    parameter int STEP_CYCLES = STEP_CYCLES_DEF,
    parameter int STEP_W      = 17
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic                blink_in,
    input  logic                enable,
    output logic [1:0]          LED,
    output logic [PWM_BITS:0]   duty,
    output logic                busy
);

    localparam logic [PWM_BITS:0] DMAX      = {1'b1, {PWM_BITS{1'b0}}};
    localparam logic [PWM_BITS:0] ONE       = (PWM_BITS+1)'(1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    fade_state_e        state;
    logic [STEP_W-1:0]  presc;
    logic               blink_q;
    logic               rise;
    logic               fall;
    logic               wrap;

    assign rise = blink_in & ~blink_q;
    assign fall = ~blink_in & blink_q;
    assign wrap = (presc == STEP_LAST);

    // busy is decoded straight from state, no register.
    assign busy = (state == RAMP_UP) || (state == RAMP_DOWN);

    // Edge detect, ramp FSM and duty prescaler. Edges take priority over a
    // prescaler wrap, and ramps always resume from the current duty.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE_OFF;
            duty    <= '0;
            presc   <= '0;
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_in;
            if (!enable) begin
                state <= IDLE_OFF;
                duty  <= '0;
                presc <= '0;
            end else if (rise) begin
                state <= RAMP_UP;
                presc <= '0;
            end else if (fall) begin
                state <= RAMP_DOWN;
                presc <= '0;
            end else begin
                case (state)
                    RAMP_UP: begin
                        if (duty == DMAX) begin
                            state <= HOLD_ON;
                            presc <= '0;
                        end else if (wrap) begin
                            presc <= '0;
                            duty  <= duty + ONE;
                            if (duty + ONE == DMAX) state <= HOLD_ON;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    RAMP_DOWN: begin
                        if (duty == '0) begin
                            state <= IDLE_OFF;
                            presc <= '0;
                        end else if (wrap) begin
                            presc <= '0;
                            duty  <= duty - ONE;
                            if (duty == ONE) state <= IDLE_OFF;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    default: presc <= '0;
                endcase
            end
        end
    end

    pwm_compare #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .duty     (duty),
        .enable   (enable),
        .led      (LED)
    );

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver with small PWM and step parameters.
module tb_led_fade_driver;

    localparam int PB = 4;

    logic          CLOCK_50;
    logic          RESET_N;
    logic          blink_in;
    logic          enable;
    logic [1:0]    LED;
    logic [PB:0]   duty;
    logic          busy;

    logic          blink_s;
    logic [1:0]    LED_s;
    logic [PB:0]   duty_s;
    logic          busy_s;

    int n_chk  = 0;
    int n_fail = 0;
    int bad;
    int c0, c1;

    led_fade_driver #(.PWM_BITS(PB), .STEP_CYCLES(4), .STEP_W(3)) u_dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .blink_in (blink_in),
        .enable   (enable),
        .LED      (LED),
        .duty     (duty),
        .busy     (busy)
    );

    // Slow-step instance so a duty value can be held across whole PWM periods.
    led_fade_driver #(.PWM_BITS(PB), .STEP_CYCLES(1000), .STEP_W(10)) u_slow (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .blink_in (blink_s),
        .enable   (1'b1),
        .LED      (LED_s),
        .duty     (duty_s),
        .busy     (busy_s)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        RESET_N  = 1'b0;
        blink_in = 1'b0;
        blink_s  = 1'b0;
        enable   = 1'b0;
        #12;
        chk("rst_led", LED, 0);
        chk("rst_duty", duty, 0);
        chk("rst_busy", busy, 0);

        // Release with enable low: everything stays dark and idle.
        tick(1);
        RESET_N = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (LED !== 2'b00 || duty !== 0 || busy !== 1'b0) bad++;
        end
        chk("idle_hold", bad, 0);

        // Enabled at duty=0: LED[1] shows full complement.
        enable = 1'b1;
        tick(1);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (LED !== 2'b10) bad++;
        end
        chk("idle_led_cmpl", bad, 0);

        // Full fade in.
        blink_in = 1'b1;
        tick(1);
        chk("up_busy", busy, 1);
        chk("up_duty0", duty, 0);
        tick(3);
        chk("up_duty_e3", duty, 0);
        tick(1);
        chk("up_duty1", duty, 1);
        tick(60);
        chk("up_duty16", duty, 16);
        chk("hold_busy", busy, 0);
        tick(1);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (LED !== 2'b01) bad++;
        end
        chk("hold_led", bad, 0);

        // Full fade out from HOLD_ON.
        blink_in = 1'b0;
        tick(1);
        chk("dn_busy", busy, 1);
        chk("dn_duty16", duty, 16);
        tick(64);
        chk("dn_duty0", duty, 0);
        chk("dn_idle_busy", busy, 0);
        tick(1);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (LED !== 2'b10) bad++;
        end
        chk("off_led", bad, 0);

        // Fall right after rise while duty is still 0: enters RAMP_DOWN at its limit.
        blink_in = 1'b1;
        tick(1);
        blink_in = 1'b0;
        tick(1);
        chk("lim_busy", busy, 1);
        chk("lim_duty", duty, 0);
        tick(1);
        chk("lim_exit", busy, 0);

        // Reversal at duty=7 continues from 7.
        blink_in = 1'b1;
        tick(29);
        chk("rev_duty7", duty, 7);
        blink_in = 1'b0;
        tick(1);
        chk("rev_nojump", duty, 7);
        chk("rev_busy", busy, 1);
        tick(3);
        chk("rev_hold7", duty, 7);
        tick(1);
        chk("rev_duty6", duty, 6);
        tick(24);
        chk("rev_duty0", duty, 0);
        chk("rev_idle", busy, 0);

        // Edge coinciding with prescaler wrap: no duty step.
        blink_in = 1'b1;
        tick(4);
        blink_in = 1'b0;
        tick(1);
        chk("wrap_edge_duty", duty, 0);
        chk("wrap_edge_busy", busy, 1);
        tick(1);
        chk("wrap_edge_idle", busy, 0);

        // Asynchronous reset mid-ramp.
        blink_in = 1'b1;
        tick(37);
        chk("mid_duty9", duty, 9);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("arst_duty", duty, 0);
        chk("arst_led", LED, 0);
        chk("arst_busy", busy, 0);
        tick(1);
        RESET_N = 1'b1;
        tick(1);
        chk("post_rst_rise", busy, 1);
        tick(20);
        chk("post_rst_duty5", duty, 5);

        // Disable mid-ramp, then re-enable without an edge.
        enable = 1'b0;
        tick(1);
        chk("dis_duty", duty, 0);
        chk("dis_busy", busy, 0);
        chk("dis_led", LED, 0);
        tick(10);
        chk("dis_led_hold", LED, 0);
        enable = 1'b1;
        tick(10);
        chk("reen_duty", duty, 0);
        chk("reen_busy", busy, 0);

        // Held duty=5: one PWM period gives 5 high on LED[0], 11 on LED[1].
        blink_s = 1'b1;
        tick(5001);
        chk("slow_duty5", duty_s, 5);
        tick(1);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (LED_s[0] === 1'b1) c0++;
            if (LED_s[1] === 1'b1) c1++;
        end
        chk("pwm_cnt_led0", c0, 5);
        chk("pwm_cnt_led1", c1, 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
